// File: rtl/axi_read_downsizer_pkg.sv
// Shared types and constants for the AXI read downsizer: the held-beat
// record, the wide/narrow width ratio and the final-sub-beat rule.
package axi_read_downsizer_pkg;

    localparam int DS_IWIDTH = 128;
    localparam int DS_OWIDTH = 32;
    localparam int DS_ID_LEN = 2;

    // Number of R sub-beats carved out of one upstream beat.
    localparam int DS_R      = DS_IWIDTH / DS_OWIDTH;
    // One spare bit so the index never wraps silently.
    localparam int DS_IDX_W  = $clog2(DS_R) + 1;

    // One upstream beat parked while its sub-beats drain onto R.
    typedef struct packed {
        logic                 valid;
        logic [DS_ID_LEN-1:0] id;
        logic [DS_IWIDTH-1:0] data;
        logic                 last;
        logic                 narrow;
    } hold_t;

    // A narrow beat ends after slice 0, a wide beat after slice R-1.
    function automatic logic is_final(input logic [DS_IDX_W-1:0] idx,
                                      input logic                narrow);
        if (narrow) begin
            return (idx == '0);
        end
        return (idx == DS_IDX_W'(DS_R - 1));
    endfunction

endpackage

// File: rtl/axi_read_downsizer.sv
// Splits IWIDTH-bit upstream read beats into OWIDTH-bit AXI R transfers.
// Ids marked narrow by a prior (or same-cycle) command emit only slice 0.
//
// Handshakes: a beat moves upstream->hold when IN_valid && OUT_ready at a
// rising clk edge; an R transfer completes when OUT_rvalid && IN_rready at
// a rising clk edge. OUT_ready is combinational from IN_rready so a new
// beat can load in the same cycle the final sub-beat leaves.
//
// The widths are fixed by axi_read_downsizer_pkg; the parameters exist for
// the port declarations and must match the package constants.
module axi_read_downsizer
    import axi_read_downsizer_pkg::*;
#(
    parameter int IWIDTH = DS_IWIDTH,
    parameter int OWIDTH = DS_OWIDTH,
    parameter int ID_LEN = DS_ID_LEN
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              IN_cmdValid,
    input  logic [ID_LEN-1:0] IN_cmdId,
    input  logic              IN_cmdNarrow,

    input  logic              IN_valid,
    output logic              OUT_ready,
    input  logic [ID_LEN-1:0] IN_id,
    input  logic [IWIDTH-1:0] IN_data,
    input  logic              IN_last,

    output logic              OUT_rvalid,
    input  logic              IN_rready,
    output logic [ID_LEN-1:0] OUT_rid,
    output logic [OWIDTH-1:0] OUT_rdata,
    output logic [1:0]        OUT_rresp,
    output logic              OUT_rlast,

    output logic              OUT_txnDone,
    output logic [ID_LEN-1:0] OUT_txnDoneId
);

    hold_t                 hold_q, hold_d;
    logic [DS_IDX_W-1:0]   idx_q, idx_d;
    logic [2**ID_LEN-1:0]  narrow_q, narrow_d;
    logic                  txn_done_q;
    logic [ID_LEN-1:0]     txn_done_id_q;

    logic                  final_sub;
    logic                  r_hs;
    logic                  accept;
    logic                  load_narrow;

    assign final_sub  = is_final(idx_q, hold_q.narrow);
    assign r_hs       = hold_q.valid && IN_rready;
    assign OUT_ready  = !hold_q.valid || (r_hs && final_sub);
    assign accept     = IN_valid && OUT_ready;

    // A command for the id being loaded this cycle overrides the table.
    assign load_narrow = (IN_cmdValid && (IN_cmdId == IN_id)) ? IN_cmdNarrow
                                                              : narrow_q[IN_id];

    assign OUT_rvalid    = hold_q.valid;
    assign OUT_rid       = hold_q.id;
    assign OUT_rdata     = hold_q.data[OWIDTH*int'(idx_q) +: OWIDTH];
    assign OUT_rresp     = 2'b00;
    assign OUT_rlast     = hold_q.valid && hold_q.last && final_sub;
    assign OUT_txnDone   = txn_done_q;
    assign OUT_txnDoneId = txn_done_id_q;

    // Next state: table write, sub-beat advance/retire, then beat load.
    always_comb begin
        hold_d   = hold_q;
        idx_d    = idx_q;
        narrow_d = narrow_q;

        if (IN_cmdValid) begin
            narrow_d[IN_cmdId] = IN_cmdNarrow;
        end

        if (r_hs) begin
            if (final_sub) begin
                idx_d        = '0;
                hold_d.valid = 1'b0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        // A load in the retire cycle wins over clearing valid.
        if (accept) begin
            hold_d.valid  = 1'b1;
            hold_d.id     = IN_id;
            hold_d.data   = IN_data;
            hold_d.last   = IN_last;
            hold_d.narrow = load_narrow;
            idx_d         = '0;
        end
    end

    // State registers; reset drops any partially emitted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q        <= '0;
            idx_q         <= '0;
            narrow_q      <= '0;
            txn_done_q    <= 1'b0;
            txn_done_id_q <= '0;
        end else begin
            hold_q        <= hold_d;
            idx_q         <= idx_d;
            narrow_q      <= narrow_d;
            txn_done_q    <= r_hs && OUT_rlast;
            txn_done_id_q <= hold_q.id;
        end
    end

    // An upstream beat must carry a known id.
    a_in_id_known: assert property (@(posedge clk) disable iff (rst)
        IN_valid |-> !$isunknown(IN_id));

    // Rewriting the narrow flag of the id currently being emitted is a
    // sequencing error upstream.
    a_no_write_held_id: assert property (@(posedge clk) disable iff (rst)
        !(IN_cmdValid && hold_q.valid && (IN_cmdId == hold_q.id)));

endmodule

// File: tb/tb_axi_read_downsizer.sv
// Self-checking bench for axi_read_downsizer: directed scenarios followed
// by randomized traffic, all compared against a transaction-level model.
module tb_axi_read_downsizer;

    localparam int IW     = 128;
    localparam int OW     = 32;
    localparam int IDL    = 2;
    localparam int R      = IW / OW;
    localparam int ITEM_W = IDL + OW + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           IN_cmdValid = 1'b0;
    logic [IDL-1:0] IN_cmdId = '0;
    logic           IN_cmdNarrow = 1'b0;
    logic           IN_valid = 1'b0;
    logic           OUT_ready;
    logic [IDL-1:0] IN_id = '0;
    logic [IW-1:0]  IN_data = '0;
    logic           IN_last = 1'b0;
    logic           OUT_rvalid;
    logic           IN_rready = 1'b0;
    logic [IDL-1:0] OUT_rid;
    logic [OW-1:0]  OUT_rdata;
    logic [1:0]     OUT_rresp;
    logic           OUT_rlast;
    logic           OUT_txnDone;
    logic [IDL-1:0] OUT_txnDoneId;

    axi_read_downsizer #(.IWIDTH(IW), .OWIDTH(OW), .ID_LEN(IDL)) dut (
        .clk           (clk),
        .rst           (rst),
        .IN_cmdValid   (IN_cmdValid),
        .IN_cmdId      (IN_cmdId),
        .IN_cmdNarrow  (IN_cmdNarrow),
        .IN_valid      (IN_valid),
        .OUT_ready     (OUT_ready),
        .IN_id         (IN_id),
        .IN_data       (IN_data),
        .IN_last       (IN_last),
        .OUT_rvalid    (OUT_rvalid),
        .IN_rready     (IN_rready),
        .OUT_rid       (OUT_rid),
        .OUT_rdata     (OUT_rdata),
        .OUT_rresp     (OUT_rresp),
        .OUT_rlast     (OUT_rlast),
        .OUT_txnDone   (OUT_txnDone),
        .OUT_txnDoneId (OUT_txnDoneId)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Scoreboard state
    int              n_checks = 0;
    int              n_fail   = 0;
    logic [ITEM_W-1:0] exp_q[$];
    logic [3:0]      model_narrow = '0;
    logic            done_pend = 1'b0;
    logic [IDL-1:0]  done_id = '0;
    logic            mon_en = 1'b0;
    logic            rready_rand = 1'b0;
    int              cyc = 0;
    int              hs_cnt = 0;
    int              acc_cyc = 0;
    int              last_hs_cyc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Monitor + reference model: every beat accepted upstream becomes a list
    // of expected R transfers; R outputs are compared in order, txnDone is
    // expected one cycle after a transfer flagged last.
    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            check("txn_done", 64'(OUT_txnDone), 64'(done_pend));
            if (done_pend) check("txn_done_id", 64'(OUT_txnDoneId), 64'(done_id));
            done_pend = 1'b0;
            if (rst) begin
                exp_q.delete();
                model_narrow = '0;
            end else begin
                check("rresp", 64'(OUT_rresp), 64'd0);
                if (OUT_rvalid) begin
                    if (exp_q.size() == 0) begin
                        check("r_unexpected", 64'd1, 64'd0);
                    end else begin
                        check("r_beat", 64'({OUT_rid, OUT_rdata, OUT_rlast}), 64'(exp_q[0]));
                        if (IN_rready) begin
                            if (exp_q[0][0]) begin
                                done_pend = 1'b1;
                                done_id   = exp_q[0][ITEM_W-1 -: IDL];
                            end
                            void'(exp_q.pop_front());
                            hs_cnt++;
                            last_hs_cyc = cyc;
                        end
                    end
                end
                if (IN_valid && OUT_ready) begin
                    logic nar;
                    nar = (IN_cmdValid && IN_cmdId == IN_id) ? IN_cmdNarrow : model_narrow[IN_id];
                    if (nar) begin
                        exp_q.push_back({IN_id, IN_data[OW-1:0], IN_last});
                    end else begin
                        for (int k = 0; k < R; k++)
                            exp_q.push_back({IN_id, IN_data[k*OW +: OW], 1'(IN_last && (k == R-1))});
                    end
                    acc_cyc = cyc;
                end
                if (IN_cmdValid) model_narrow[IN_cmdId] = IN_cmdNarrow;
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
        if (rready_rand) IN_rready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_beat(input logic [IDL-1:0] id, input logic [IW-1:0] data, input logic last);
        int   n;
        logic acc;
        n = 0;
        acc = 1'b0;
        IN_valid = 1'b1;
        IN_id    = id;
        IN_data  = data;
        IN_last  = last;
        while (!acc && n < 500) begin
            @(negedge clk);
            acc = OUT_ready;
            tick();
            n++;
        end
        IN_valid = 1'b0;
        if (!acc) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic set_cmd(input logic [IDL-1:0] id, input logic nar);
        IN_cmdValid  = 1'b1;
        IN_cmdId     = id;
        IN_cmdNarrow = nar;
        tick();
        IN_cmdValid  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        tick();
        tick();
    endtask

    function automatic logic [IW-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int             h0;
        int             a0;
        int             n;
        logic [IW-1:0]  d;

        // Reset
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("reset_rvalid", 64'(OUT_rvalid), 64'd0);
        check("reset_ready", 64'(OUT_ready), 64'd1);
        check("reset_txn_done", 64'(OUT_txnDone), 64'd0);
        tick();

        // Wide beat, rready held high: four consecutive slices.
        IN_rready = 1'b1;
        h0 = hs_cnt;
        send_beat(2'd1, 128'h44444444_33333333_22222222_11111111, 1'b1);
        a0 = acc_cyc;
        drain();
        check("wide_count", 64'(hs_cnt - h0), 64'(R));
        check("wide_latency", 64'(last_hs_cyc - a0), 64'(R));

        // Narrow id: a single transfer, upstream ready in the same cycle.
        set_cmd(2'd2, 1'b1);
        h0 = hs_cnt;
        send_beat(2'd2, {96'h0123_4567_89ab_cdef_0011_2233, 32'hDEADBEEF}, 1'b1);
        @(negedge clk);
        check("narrow_rdata", 64'(OUT_rdata), 64'hDEADBEEF);
        check("narrow_rlast", 64'(OUT_rlast), 64'd1);
        check("narrow_ready", 64'(OUT_ready), 64'd1);
        drain();
        check("narrow_count", 64'(hs_cnt - h0), 64'd1);

        // Two back-to-back beats: eight transfers without a gap.
        h0 = hs_cnt;
        send_beat(2'd0, rand_data(), 1'b0);
        a0 = acc_cyc;
        send_beat(2'd0, rand_data(), 1'b1);
        drain();
        check("b2b_count", 64'(hs_cnt - h0), 64'(2*R));
        check("b2b_latency", 64'(last_hs_cyc - a0), 64'(2*R));

        // Stall on sub-beat 1: rready 1,0,0,1.
        h0 = hs_cnt;
        d = rand_data();
        send_beat(2'd0, d, 1'b1);
        tick();
        IN_rready = 1'b0;
        @(negedge clk);
        check("stall_data_a", 64'(OUT_rdata), 64'(d[2*OW-1:OW]));
        tick();
        @(negedge clk);
        check("stall_data_b", 64'(OUT_rdata), 64'(d[2*OW-1:OW]));
        tick();
        IN_rready = 1'b1;
        drain();
        check("stall_count", 64'(hs_cnt - h0), 64'(R));

        // Narrow command forwarded into the load cycle of the same id.
        h0 = hs_cnt;
        IN_cmdValid  = 1'b1;
        IN_cmdId     = 2'd3;
        IN_cmdNarrow = 1'b1;
        send_beat(2'd3, rand_data(), 1'b1);
        IN_cmdValid  = 1'b0;
        drain();
        check("fwd_count", 64'(hs_cnt - h0), 64'd1);
        h0 = hs_cnt;
        send_beat(2'd3, rand_data(), 1'b1);
        drain();
        check("fwd_table_count", 64'(hs_cnt - h0), 64'd1);

        // Reset after sub-beat 2 of a wide beat; table must come back wide.
        set_cmd(2'd0, 1'b1);
        h0 = hs_cnt;
        send_beat(2'd1, rand_data(), 1'b1);
        n = 0;
        while ((hs_cnt - h0) < 3 && n < 100) begin
            tick();
            n++;
        end
        check("pre_reset_count", 64'(hs_cnt - h0), 64'd3);
        rst = 1'b1;
        IN_rready = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_rvalid", 64'(OUT_rvalid), 64'd0);
        check("post_reset_ready", 64'(OUT_ready), 64'd1);
        tick();
        IN_rready = 1'b1;
        h0 = hs_cnt;
        send_beat(2'd0, rand_data(), 1'b1);
        drain();
        check("post_reset_count", 64'(hs_cnt - h0), 64'(R));

        // Randomized traffic with random rready and upstream gaps.
        rready_rand = 1'b1;
        for (int g = 0; g < 10; g++) begin
            drain();
            set_cmd(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            for (int b = 0; b < 6; b++) begin
                repeat ($urandom_range(0, 2)) tick();
                send_beat(2'($urandom_range(0, 3)), rand_data(), 1'($urandom_range(0, 1)));
            end
        end
        rready_rand = 1'b0;
        IN_rready = 1'b1;
        drain();
        check("final_queue", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_read_downsizer.md
AXI_READ_DOWNSIZER -- requirements
Module: axi_read_downsizer

Interface
REQ-001 SHALL have parameter IWIDTH, default 128, meaning the upstream beat width in bits.
REQ-002 SHALL have parameter OWIDTH, default 32, meaning the AXI R data width in bits; IWIDTH is an integer multiple of OWIDTH, with R = IWIDTH/OWIDTH.
REQ-003 SHALL have parameter ID_LEN, default 2, meaning the transaction id width.
REQ-004 SHALL have port clk, input, 1 bit: clock.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port IN_cmdValid, input, 1 bit: a command for id IN_cmdId is issued this cycle.
REQ-007 SHALL have port IN_cmdId, input, ID_LEN bits: command id.
REQ-008 SHALL have port IN_cmdNarrow, input, 1 bit: 1 emits only sub-beat 0 of each beat for this id (mmio/32-bit access).
REQ-009 SHALL have port IN_valid, input, 1 bit: upstream beat valid.
REQ-010 SHALL have port OUT_ready, output, 1 bit: upstream beat accepted when high together with IN_valid.
REQ-011 SHALL have ports IN_id (ID_LEN bits), IN_data (IWIDTH bits) and IN_last (1 bit), all inputs, carrying the upstream beat payload.
REQ-012 SHALL have ports OUT_rvalid (output, 1 bit) and IN_rready (input, 1 bit) forming the AXI R handshake.
REQ-013 SHALL have ports OUT_rid (ID_LEN bits), OUT_rdata (OWIDTH bits), OUT_rresp (2 bits) and OUT_rlast (1 bit), all outputs.
REQ-014 SHALL have ports OUT_txnDone (output, 1 bit) and OUT_txnDoneId (output, ID_LEN bits) forming a one-cycle completion pulse.

Function
REQ-015 SHALL hold one beat register {valid, id, data, last, narrow} and a sub-beat index idx, width clog2(R)+1.
REQ-016 SHALL drive OUT_rvalid = hold.valid, OUT_rdata = hold.data[idx*OWIDTH +: OWIDTH], OUT_rid = hold.id, and OUT_rresp = 2'b00 always.
REQ-017 SHALL treat the current sub-beat as final when idx == R-1, or when hold.narrow is 1 (then idx == 0 only).
REQ-018 SHALL assert OUT_rlast = hold.valid && hold.last && final.
REQ-019 SHALL drive OUT_ready = !hold.valid || (OUT_rvalid && IN_rready && final), a combinational path from IN_rready, so back-to-back beats incur no bubble.
REQ-020 SHALL, on an R handshake of a non-final sub-beat, set idx <= idx+1.
REQ-021 SHALL, on an R handshake of the final sub-beat, set idx <= 0, and SHALL set hold.valid <= 0 unless a new beat is accepted in the same cycle.
REQ-022 SHALL, on upstream acceptance, load the hold register with idx <= 0, and SHALL make the first sub-beat visible the next cycle (1-cycle latency).
REQ-023 SHALL keep all R outputs stable while OUT_rvalid && !IN_rready.
REQ-024 SHALL maintain a 2^ID_LEN-entry narrow table, written on IN_cmdValid.
REQ-025 SHALL take hold.narrow from the table at load time; when IN_cmdValid && IN_cmdId == IN_id in the load cycle, IN_cmdNarrow SHALL be forwarded.
REQ-026 SHALL pulse OUT_txnDone for one cycle, registered, the cycle after an R handshake with OUT_rlast = 1, with OUT_txnDoneId = that rid.
REQ-027 SHALL, for a narrow beat, emit exactly one R transfer; the other R-1 slices SHALL be discarded.
REQ-028 SHALL drive OUT_rdata, OUT_rid and OUT_rlast as don't-care while OUT_rvalid = 0.
REQ-029 SHALL flag, via assertion only, IN_valid with X on IN_id and a table write to an id that is currently held.

Reset
REQ-030 SHALL, while rst is high at a clk edge, clear hold.valid, idx, the table (all wide), and OUT_txnDone.
REQ-031 SHALL drive outputs after reset as OUT_rvalid = 0, OUT_ready = 1 and OUT_txnDone = 0.
REQ-032 SHALL, on a reset asserted mid-transaction, drop the partially emitted beat with no further R output.

Structure
REQ-033 SHALL place the hold-register struct type and the R = IWIDTH/OWIDTH constant in the shared cache package.
REQ-034 SHALL be flat, with no sub-modules; the table is a flop array, not a memory macro.

Verification
REQ-035 SHALL cover: wide id 1, one beat 0x44443333_22221111_... with last=1 and rready held 1 -> rdata 0x..1111, 0x..2222, 0x..3333, 0x..4444 on consecutive cycles, rlast only on the 4th, txnDone id 1 one cycle later.
REQ-036 SHALL cover: cmd narrow for id 2, then beat data[31:0] = 0xDEADBEEF with last=1 -> a single R transfer 0xDEADBEEF with rlast=1, and OUT_ready high again the same cycle.
REQ-037 SHALL cover: two back-to-back beats of id 0 (last=0 then last=1) with rready=1 -> 8 R transfers with no gap and rlast only on the 8th.
REQ-038 SHALL cover: rready toggling 1,0,0,1 during sub-beat 1 -> rdata and idx held stable through the stall, with no duplication or skip.
REQ-039 SHALL cover: cmd narrow for id 3 in the same cycle as a beat of id 3 is accepted -> the beat is treated as narrow (forwarding).
REQ-040 SHALL cover: rst asserted after sub-beat 2 of 4 -> OUT_rvalid=0 the next cycle, table cleared, and a subsequent beat emitted from sub-beat 0.
